// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read and write controllers.
package fifo_pkg;

    localparam int FIFO_ADDR_W = 8;
    localparam int FIFO_DATA_W = 8;

    // Pointers are widened to this size before subtracting, so any ADDR_W up to 31 is supported.
    localparam int PTR_MAX_W = 32;

    // The caller truncates the result to its own pointer width to get the modular difference.
    function automatic logic [PTR_MAX_W-1:0] ptr_diff(
        input logic [PTR_MAX_W-1:0] wr,
        input logic [PTR_MAX_W-1:0] rd
    );
        return wr - rd;
    endfunction

endpackage

// File: rtl/fifo_out_stage.sv
// Output register of the FIFO read path: holds out_valid and decides when a RAM read may be issued.
module fifo_out_stage (
    input  logic clk,
    input  logic rst_n,
    input  logic avail_i,
    input  logic flush_i,
    input  logic out_ready_i,
    output logic rd_en_o,
    output logic out_valid_o
);

    logic valid_q;
    logic valid_d;

    // The output slot can take a new word when it is empty or when its current word leaves this cycle.
    assign rd_en_o = avail_i && !flush_i && (!valid_q || out_ready_i);

    always_comb begin
        valid_d = rd_en_o || (valid_q && !out_ready_i);
        if (flush_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign out_valid_o = valid_q;

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-side controller of the single-clock FIFO: owns the read pointer and streams RAM data downstream.
module fifo_read_ctrl
    import fifo_pkg::*;
#(
    parameter int          ADDR_W   = FIFO_ADDR_W,
    parameter int          DATA_W   = FIFO_DATA_W,
    parameter int unsigned AE_LEVEL = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W:0]   wr_ptr,
    input  logic              flush,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W:0]   rd_ptr,
    output logic [ADDR_W:0]   level,
    output logic              empty,
    output logic              almost_empty,
    output logic              ovf_err
);

    localparam int              PTR_W  = ADDR_W + 1;
    localparam logic [PTR_W-1:0] DEPTH  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [PTR_W-1:0] AE_THR = PTR_W'(AE_LEVEL);

    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic             ovf_q;
    logic             ovf_d;
    logic [PTR_W-1:0] stored;
    logic             avail;
    logic             rd_en;
    logic             vld;

    assign stored = PTR_W'(ptr_diff(PTR_MAX_W'(wr_ptr), PTR_MAX_W'(rd_ptr_q)));
    assign avail  = (stored != '0);

    fifo_out_stage u_out_stage (
        .clk         (clk),
        .rst_n       (rst_n),
        .avail_i     (avail),
        .flush_i     (flush),
        .out_ready_i (out_ready),
        .rd_en_o     (rd_en),
        .out_valid_o (vld)
    );

    // Flush resynchronises to the writer and wins over any read in the same cycle.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            rd_ptr_d = wr_ptr;
        end else if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        ovf_d = ovf_q || (stored > DEPTH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    // The word sitting in the output register still counts as held by the FIFO.
    assign level        = stored + {{ADDR_W{1'b0}}, vld};
    assign empty        = (level == '0);
    assign almost_empty = (level <= AE_THR);

    assign ram_rd_en   = rd_en;
    assign ram_rd_addr = rd_ptr_q[ADDR_W-1:0];
    assign out_valid   = vld;
    assign out_data    = ram_rd_data;
    assign rd_ptr      = rd_ptr_q;
    assign ovf_err     = ovf_q;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl with a RAM model and an occupancy-based reference model.
module tb_fifo_read_ctrl;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int AE = 4;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b1;
    logic          flush     = 1'b0;
    logic          out_ready = 1'b1;
    logic [AW:0]   wr_ptr    = '0;
    logic          ram_rd_en;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data = '0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   level;
    logic          empty;
    logic          almost_empty;
    logic          ovf_err;

    logic [DW-1:0] mem [256];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fifo_read_ctrl #(.ADDR_W(AW), .DATA_W(DW), .AE_LEVEL(AE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_ptr       (wr_ptr),
        .flush        (flush),
        .ram_rd_en    (ram_rd_en),
        .ram_rd_addr  (ram_rd_addr),
        .ram_rd_data  (ram_rd_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .rd_ptr       (rd_ptr),
        .level        (level),
        .empty        (empty),
        .almost_empty (almost_empty),
        .ovf_err      (ovf_err)
    );

    // Synchronous-read RAM: data appears the cycle after the enable and is held otherwise.
    always @(posedge clk) begin
        if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO is the word range [m_rd, wr_ptr) plus a one-word output slot.
    int          m_rd  = 0;
    bit          m_hv  = 1'b0;
    logic [7:0]  m_hd  = '0;
    bit          m_ovf = 1'b0;
    int          s_now;
    int          n_rd;
    bit          n_hv;
    logic [7:0]  n_hd;
    bit          n_ovf;
    bit          e_rden;
    int          e_level;

    always_comb begin
        s_now   = (int'(wr_ptr) + 512 - m_rd) % 512;
        e_level = (s_now + int'(m_hv)) % 512;
        e_rden  = (s_now > 0) && !flush && (!m_hv || out_ready);
        n_rd    = m_rd;
        n_hv    = m_hv;
        n_hd    = m_hd;
        n_ovf   = m_ovf || (s_now > 256);
        if (flush) begin
            n_rd = int'(wr_ptr);
            n_hv = 1'b0;
        end else if (s_now > 0 && (!m_hv || out_ready)) begin
            n_hd = mem[8'(m_rd)];
            n_rd = (m_rd + 1) % 512;
            n_hv = 1'b1;
        end else if (m_hv && out_ready) begin
            n_hv = 1'b0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rd  <= 0;
            m_hv  <= 1'b0;
            m_ovf <= 1'b0;
        end else begin
            m_rd  <= n_rd;
            m_hv  <= n_hv;
            m_hd  <= n_hd;
            m_ovf <= n_ovf;
        end
    end

    always @(negedge clk) begin
        chk("m_rd_ptr",       rd_ptr,       m_rd);
        chk("m_out_valid",    out_valid,    m_hv);
        chk("m_level",        level,        e_level);
        chk("m_empty",        empty,        e_level == 0);
        chk("m_almost_empty", almost_empty, e_level <= AE);
        chk("m_ram_rd_en",    ram_rd_en,    e_rden);
        chk("m_ram_rd_addr",  ram_rd_addr,  m_rd % 256);
        chk("m_ovf_err",      ovf_err,      m_ovf);
        if (m_hv) chk("m_out_data", out_data, m_hd);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
        mem[0] = 8'h11;
        mem[1] = 8'h22;
        mem[2] = 8'h33;

        #1 rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            step(); #1;
            chk("rst_empty", empty,     1);
            chk("rst_level", level,     0);
            chk("rst_rden",  ram_rd_en, 0);
            chk("rst_vld",   out_valid, 0);
        end

        // Three words, always ready
        wr_ptr = 9'h003; #1;
        chk("s_rden0", ram_rd_en, 1); chk("s_addr0", ram_rd_addr, 8'h00); chk("s_vld0", out_valid, 0);
        step(); #1;
        chk("s_rden1", ram_rd_en, 1); chk("s_addr1", ram_rd_addr, 8'h01); chk("s_data1", out_data, 8'h11);
        step(); #1;
        chk("s_rden2", ram_rd_en, 1); chk("s_data2", out_data, 8'h22); chk("s_vld2", out_valid, 1);
        step(); #1;
        chk("s_rden3", ram_rd_en, 0); chk("s_data3", out_data, 8'h33); chk("s_rdptr3", rd_ptr, 3);
        step(); #1;
        chk("s_vld4", out_valid, 0); chk("s_empty4", empty, 1); chk("s_rdptr4", rd_ptr, 3);

        // Backpressure
        wr_ptr = '0; rst_n = 1'b0;
        step();
        rst_n = 1'b1; out_ready = 1'b0; wr_ptr = 9'h003; #1;
        chk("bp_rden0", ram_rd_en, 1);
        step(); #1;
        chk("bp_vld1", out_valid, 1); chk("bp_data1", out_data, 8'h11);
        chk("bp_rden1", ram_rd_en, 0); chk("bp_level1", level, 3);
        step(); #1;
        chk("bp_data2", out_data, 8'h11); chk("bp_level2", level, 3); chk("bp_rdptr2", rd_ptr, 1);
        out_ready = 1'b1; #1;
        chk("bp_rden3", ram_rd_en, 1);
        step(); #1;
        chk("bp_data4", out_data, 8'h22); chk("bp_vld4", out_valid, 1);
        step(); #1;
        chk("bp_data5", out_data, 8'h33); chk("bp_vld5", out_valid, 1);
        step(); #1;
        chk("bp_vld6", out_valid, 0); chk("bp_rdptr6", rd_ptr, 3);

        // Pointer wrap through 0x1FF
        out_ready = 1'b0; flush = 1'b1; wr_ptr = 9'h100;
        step();
        wr_ptr = 9'h1FE;
        step(); #1;
        chk("w_rdptr_preset", rd_ptr, 9'h1FE); chk("w_ovf", ovf_err, 0);
        flush = 1'b0; wr_ptr = 9'h002; out_ready = 1'b1; #1;
        chk("w_level", level, 4); chk("w_addr0", ram_rd_addr, 8'hFE); chk("w_rden0", ram_rd_en, 1);
        step(); #1;
        chk("w_addr1", ram_rd_addr, 8'hFF); chk("w_data1", out_data, mem[8'hFE]);
        step(); #1;
        chk("w_addr2", ram_rd_addr, 8'h00); chk("w_data2", out_data, mem[8'hFF]);
        step(); #1;
        chk("w_addr3", ram_rd_addr, 8'h01); chk("w_data3", out_data, 8'h11);
        step(); #1;
        chk("w_rden4", ram_rd_en, 0); chk("w_rdptr4", rd_ptr, 9'h002); chk("w_data4", out_data, 8'h22);
        step();

        // Full FIFO and almost_empty threshold
        wr_ptr = '0; rst_n = 1'b0;
        step();
        rst_n = 1'b1; out_ready = 1'b0; wr_ptr = 9'h100; #1;
        chk("f_level", level, 256); chk("f_ae", almost_empty, 0); chk("f_empty", empty, 0);
        step(); #1;
        chk("f_level_vld", level, 256);
        out_ready = 1'b1; #1;
        for (int k = 0; k < 300 && level != 4; k++) begin
            if (level == 5) chk("f_ae_at5", almost_empty, 0);
            step(); #1;
        end
        chk("f_level_drained", level, 4); chk("f_ae_at4", almost_empty, 1);
        for (int k = 0; k < 6; k++) step();
        #1;
        chk("f_empty_end", empty, 1); chk("f_rdptr_end", rd_ptr, 9'h100);

        // Flush with data pending
        out_ready = 1'b0; wr_ptr = 9'h106;
        step(); #1;
        chk("fl_vld", out_valid, 1); chk("fl_level", level, 6);
        flush = 1'b1; #1;
        chk("fl_rden", ram_rd_en, 0);
        step();
        flush = 1'b0; #1;
        chk("fl_rdptr", rd_ptr, 9'h106); chk("fl_vld_after", out_valid, 0); chk("fl_empty", empty, 1);

        // Overflow is sticky until reset
        out_ready = 1'b1; wr_ptr = 9'h007;
        step(); #1;
        chk("o_set", ovf_err, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        step(); step(); step(); #1;
        chk("o_hold", ovf_err, 1); chk("o_empty", empty, 1);

        // Asynchronous reset in the middle of a read
        out_ready = 1'b0; wr_ptr = 9'h00A;
        step(); #1;
        chk("r_vld_before", out_valid, 1);
        rst_n = 1'b0; #1;
        chk("r_vld", out_valid, 0); chk("r_rdptr", rd_ptr, 0); chk("r_ovf", ovf_err, 0);
        wr_ptr = '0;
        step();
        rst_n = 1'b1;
        step(); step(); #1;
        chk("r_empty_end", empty, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_read_ctrl.md
Name: fifo_read_ctrl

Overview:
- Read-side controller for the single-clock 2^ADDR_W-deep FIFO built around the dual-port RAM.
- Counterpart of the write-side pointer/occupancy logic: consumes the writer's pointer and owns the read pointer.
- Issues synchronous RAM reads and presents data downstream on a valid/ready interface with full throughput.
- Returns its read pointer to the writer for full detection.

Parameters:
- ADDR_W, 8, RAM address width; FIFO depth DEPTH = 2^ADDR_W (256).
- DATA_W, 8, data width.
- AE_LEVEL, 4, almost_empty threshold (asserted when level <= AE_LEVEL).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_ptr  in  ADDR_W+1  writer pointer; MSB is the wrap bit, low ADDR_W bits are the address.
- flush  in  1  synchronous discard of all unread data.
- ram_rd_en  out  1  RAM read enable (combinational).
- ram_rd_addr  out  ADDR_W  RAM read address = rd_ptr[ADDR_W-1:0].
- ram_rd_data  in  DATA_W  RAM read data; valid the cycle after ram_rd_en; held while ram_rd_en=0.
- out_valid  out  1  downstream data valid (registered).
- out_ready  in  1  downstream accept.
- out_data  out  DATA_W  equals ram_rd_data.
- rd_ptr  out  ADDR_W+1  read pointer (registered), returned to the writer.
- level  out  ADDR_W+1  entries held = stored + out_valid, range 0..DEPTH.
- empty  out  1  level == 0.
- almost_empty  out  1  level <= AE_LEVEL.
- ovf_err  out  1  sticky: pointer difference exceeded DEPTH.

Behaviour:
- Reset (async assert, sync release): rd_ptr=0, out_valid=0, ovf_err=0. Hence level=0, empty=1, almost_empty=1, ram_rd_en=0.
- Pointer arithmetic:
  - stored = (wr_ptr - rd_ptr) mod 2^(ADDR_W+1); unsigned, no sign extension.
  - Wrap handled by the modular subtract. Example: wr_ptr=0x002, rd_ptr=0x1FE -> stored=4.
  - Equal pointers -> stored=0. Low bits equal and MSB differs -> stored=DEPTH (full).
- avail = (stored != 0).
- ram_rd_en = avail && !flush && (!out_valid || out_ready).
- On ram_rd_en: rd_ptr <= rd_ptr + 1, wrapping naturally 0x1FF -> 0x000.
- Output register update: out_valid <= ram_rd_en || (out_valid && !out_ready).
  - Read latency is 1 cycle: a read issued in cycle N gives out_valid=1 in cycle N+1.
  - Back-to-back reads give 1 word per cycle.
- While out_valid && !out_ready:
  - no read is issued;
  - out_data is held stable, relying on the RAM holding data when ram_rd_en=0.
- Simultaneous events:
  - Consume and refill in the same cycle: out_valid stays 1 and out_data updates next cycle.
  - Writer advances wr_ptr in the same cycle as a read: the new wr_ptr is used for the next cycle's stored value only. No combinational path from wr_ptr to rd_ptr other than through avail.
- Empty boundary: when stored=0, no read is issued. out_valid may still be 1 from the last fetched word.
- flush (highest priority): next cycle rd_ptr <= wr_ptr (current value), out_valid <= 0, no read issued that cycle.
- ovf_err: set when stored > DEPTH. Cleared only by rst_n. The block keeps operating with modular arithmetic.
- Reset mid-operation: outputs return to reset values immediately (async). The in-flight RAM read is discarded.

Decomposition:
- Shared package fifo_pkg:
  - ADDR_W and DATA_W defaults;
  - function ptr_diff(wr, rd) returning the (ADDR_W+1)-bit modular difference, also reused by the write-side controller.
- One natural sub-module: fifo_out_stage, holding the out_valid register and the ram_rd_en/accept handshake logic.
- Pointer register, level, flags and ovf_err stay in the top.

Test Plan:
- Reset, wr_ptr=0, out_ready=1 -> empty=1, level=0, ram_rd_en=0, out_valid=0 for 10 cycles.
- wr_ptr steps 0->3 in one cycle (RAM holds 0x11,0x22,0x33), out_ready=1:
  - ram_rd_en high 3 consecutive cycles;
  - out_data 0x11,0x22,0x33 on consecutive cycles, starting 1 cycle after the first read;
  - final rd_ptr=3, empty=1.
- Backpressure: 3 entries, out_ready=0 -> exactly one read, out_valid=1, out_data=0x11 held, level=3. Raise out_ready -> remaining 2 words stream out with no gaps.
- Wrap: rd_ptr preset via flush to 0x1FE, wr_ptr=0x002 -> level=4; 4 reads at addresses 0xFE,0xFF,0x00,0x01; rd_ptr ends at 0x002.
- Full: wr_ptr=0x100, rd_ptr=0x000 -> level=256, almost_empty=0. Drain to 4 entries -> almost_empty=1.
- flush with 5 stored and out_valid=1 -> next cycle rd_ptr=wr_ptr, out_valid=0, empty=1. Separately, wr_ptr=0x101 vs rd_ptr=0 -> ovf_err=1 and stays 1 until rst_n.
